// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one result bit per BUSY cycle, with valid/ready on both sides and a pipeline kill.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on in_valid && in_ready, a result on
    // out_valid && out_ready; kill overrides both and drops any op in flight.

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op;
    logic             neg;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  mb;
    logic [CNT_W-1:0] cnt;

    logic            legal, is_div, a_signed, b_signed, sa, sb, div0, ovf, neg_in;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    always_comb begin
        legal    = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        sa       = a_signed & rs1[XLEN-1];
        sb       = b_signed & rs2[XLEN-1];
        mag_a    = sa ? -rs1 : rs1;
        mag_b    = sb ? -rs2 : rs2;
        // Remainder takes the dividend's sign; everything else the xor of both.
        neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
        div0     = is_div && (rs2 == '0);
        ovf      = is_div && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        fast_res = '0;
        if (div0) begin
            fast_res = funct3[1] ? rs1 : '1;
        end else if (ovf) begin
            fast_res = funct3[1] ? '0 : rs1;
        end
    end

    // lo holds multiplier bits (shifted out) or dividend bits (shifted into quotient).
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_nx, lo_nx, q_fin, r_fin, final_res;
    logic [2*XLEN-1:0] prod_fin;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mb};
        if (op[2]) begin
            hi_nx = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod_fin = neg ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        q_fin    = neg ? -lo_nx : lo_nx;
        r_fin    = neg ? -hi_nx : hi_nx;
        case (op)
            3'b000:                 final_res = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = q_fin;
            default:                final_res = r_fin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            illegal   <= 1'b0;
            op        <= '0;
            neg       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mb        <= '0;
            cnt       <= '0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_tag <= in_tag;
                        op      <= funct3;
                        neg     <= neg_in;
                        hi      <= '0;
                        lo      <= is_div ? mag_a : mag_b;
                        mb      <= is_div ? mag_b : mag_a;
                        cnt     <= '0;
                        illegal <= !legal;
                        if (!legal) begin
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (div0 || ovf) begin
                            result    <= fast_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi <= hi_nx;
                    lo <= lo_nx;
                    if (cnt == LAST) begin
                        result    <= final_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): literal directed cases plus randomized ops with
// random backpressure and kills, checked every cycle against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = 7'b0110011;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'b0000001;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        illegal;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
        .in_tag(in_tag), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference result straight from the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [6:0] opc, input logic [6:0] f7,
                                            input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, output bit ill, output bit fast);
        longint sa, sb, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ill = 1'b0;
        fast = 1'b0;
        if (opc != 7'b0110011 || f7 != 7'b0000001) begin
            ill = 1'b1;
            fast = 1'b1;
            return '0;
        end
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) begin fast = 1'b1; return '1; end
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin fast = 1'b1; return a; end
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) begin fast = 1'b1; return '1; end
                return a / b;
            end
            3'd6: begin
                if (b == 0) begin fast = 1'b1; return a; end
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin fast = 1'b1; return '0; end
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) begin fast = 1'b1; return a; end
                return a % b;
            end
        endcase
    endfunction

    // Transaction-level model: one op in flight, fixed latency, result held until taken.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  exp_tag = '0;
    bit          exp_ill = 1'b0;

    always @(posedge clk) begin
        bit ill, fast;
        logic [31:0] r;
        if (rst) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
            exp_q.delete();
        end else if (kill) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
            exp_q.delete();
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            r = ref_res(opcode, funct7, funct3, rs1, rs2, ill, fast);
            exp_q.push_back(r);
            exp_tag = in_tag;
            exp_ill = ill;
            m_busy = 1'b1;
            if (fast) m_valid = 1'b1;
            else m_cnt = 32;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_in_ready", 32'(in_ready), 32'(!m_busy));
            if (m_valid && exp_q.size() > 0) begin
                chk("m_result", result, exp_q[0]);
                chk("m_tag", 32'(out_tag), 32'(exp_tag));
                chk("m_illegal", 32'(illegal), 32'(exp_ill));
            end
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int w;
        @(posedge clk); #1;
        opcode = opc; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b; in_tag = tag;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic op_lit(input string name, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] lit, input int lat, input bit ill, input int stall);
        int cyc;
        issue(7'b0110011, f7, f3, a, b, tag);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 100);
        chk({name, "_lat"}, 32'(cyc), 32'(lat));
        chk({name, "_res"}, result, lit);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_ill"}, 32'(illegal), 32'(ill));
        repeat (stall) begin
            @(negedge clk);
            chk({name, "_hold_res"}, result, lit);
            chk({name, "_hold_tag"}, 32'(out_tag), 32'(tag));
            chk({name, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_post_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        op_lit("mul_bp",    7'h01, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 1'b0, 5);
        op_lit("mulhu",     7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33, 1'b0, 0);
        op_lit("mulh",      7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, 33, 1'b0, 0);
        op_lit("mulhsu",    7'h01, 3'b010, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 33, 1'b0, 0);
        op_lit("div",       7'h01, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 33, 1'b0, 0);
        op_lit("rem",       7'h01, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33, 1'b0, 0);
        op_lit("divu_zero", 7'h01, 3'b101, 32'd100, 32'd0, 5'd7, 32'hFFFFFFFF, 1, 1'b0, 0);
        op_lit("div_ovf",   7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1, 1'b0, 0);
        op_lit("rem_ovf",   7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h0, 1, 1'b0, 0);
        op_lit("illegal",   7'h00, 3'b000, 32'd5, 32'd6, 5'd11, 32'h0, 1, 1'b1, 0);

        // Kill during the tenth BUSY cycle, then a fresh op must run cleanly.
        issue(7'b0110011, 7'h01, 3'b101, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_out_valid", 32'(out_valid), 32'd0);
        chk("kill_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        op_lit("divu_after_kill", 7'h01, 3'b101, 32'd9, 32'd4, 5'd9, 32'd2, 33, 1'b0, 0);

        // Kill together with in_valid in IDLE must not accept.
        @(posedge clk); #1;
        opcode = 7'b0110011; funct7 = 7'h01; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
        in_valid = 1'b1;
        kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill = 1'b0;
        @(negedge clk);
        chk("killin_in_ready", 32'(in_ready), 32'd1);
        chk("killin_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            logic [6:0] opc, f7;
            logic [2:0] f3;
            logic [31:0] a, b;
            bit do_kill;
            int kat, w;
            opc = 7'b0110011;
            f7 = 7'b0000001;
            f3 = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if ($urandom_range(0, 9) == 0) f7 = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 19) == 0) opc = 7'($urandom_range(0, 127));
            do_kill = ($urandom_range(0, 7) == 0);
            kat = $urandom_range(0, 40);
            issue(opc, f7, f3, a, b, 5'($urandom_range(0, 31)));
            w = 0;
            while (m_busy && w < 300) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                kill = do_kill && (w == kat);
                w++;
            end
            kill = 1'b0;
            out_ready = 1'b0;
            chk("rand_drain", 32'(m_busy), 32'd0);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
